cdb_multilane: RTL and testbench

- Parametrised successor to the backend common data bus.
- Arbitrates ISSUER result producers (execution units, reorder-buffer commit) onto BUS_LANES parallel broadcast lanes per cycle, with fixed-priority or round-robin selection.
- Lanes are registered, then drive ROB writeback, arch-register writeback and LISTENER tag-match ports (issuer rs1/rs2 fetch/issue snoops).
- Sits between the function units / ReorderBuffer and the InstIssuer / ReorderBuffer / arch register file.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/cdb_multilane_if.sv | 45 ++++
 rtl/cdb_lane_arbiter.sv | 61 ++++++
 rtl/cdb_multilane.sv | 125 ++++++++++++
 tb/tb_cdb_multilane.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared constants, lane record and width helper for the multi-lane common data bus.
package cdb_pkg;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

   localparam int unsigned CDB_TAG_W  = 2;
   localparam int unsigned CDB_ARCH_W = 5;
   localparam int unsigned CDB_DATA_W = 32;

   // Lane record at the default geometry; cdb_multilane re-declares it at its own widths.
   typedef struct packed {
      logic                  valid;
      logic                  is_arch;
      logic [CDB_TAG_W-1:0]  rob_id;
      logic [CDB_ARCH_W-1:0] arch_id;
      logic [CDB_DATA_W-1:0] data;
   } cdb_lane_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_multilane_if.sv
// Issuer, writeback and listener signals of the multi-lane common data bus.
interface cdb_multilane_if
   import cdb_pkg::*;
#(
   parameter int unsigned ISSUER     = 4,
   parameter int unsigned LISTENER   = 4,
   parameter int unsigned BUS_LANES  = 2,
   parameter int unsigned ROB_ENTRY  = 4,
   parameter int unsigned ARCH_ENTRY = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned TagW  = idx_width(ROB_ENTRY);
   localparam int unsigned ArchW = idx_width(ARCH_ENTRY);

   logic [ISSUER-1:0]               cdb_isr_request;
   logic [ISSUER-1:0]               cdb_isr_grant;
   logic [ISSUER*TagW-1:0]          cdb_isr_id;
   logic [ISSUER*DATA_WIDTH-1:0]    cdb_isr_data;
   logic [ISSUER*ArchW-1:0]         cdb_isr_arch_id;
   logic [BUS_LANES-1:0]            rob_write;
   logic [BUS_LANES*TagW-1:0]       rob_id;
   logic [BUS_LANES*DATA_WIDTH-1:0] rob_data;
   logic [BUS_LANES-1:0]            arch_reg_write;
   logic [BUS_LANES*ArchW-1:0]      arch_reg_id;
   logic [BUS_LANES*DATA_WIDTH-1:0] arch_reg_data;
   logic [LISTENER-1:0]             cdb_lsn_request;
   logic [LISTENER*TagW-1:0]        cdb_lsn_id;
   logic [LISTENER-1:0]             cdb_lsn_hit;
   logic [LISTENER*DATA_WIDTH-1:0]  cdb_lsn_data;

   modport master (
      output cdb_isr_request, cdb_isr_id, cdb_isr_data, cdb_isr_arch_id,
      output cdb_lsn_request, cdb_lsn_id,
      input  cdb_isr_grant, rob_write, rob_id, rob_data,
      input  arch_reg_write, arch_reg_id, arch_reg_data, cdb_lsn_hit, cdb_lsn_data
   );

   modport slave (
      input  cdb_isr_request, cdb_isr_id, cdb_isr_data, cdb_isr_arch_id,
      input  cdb_lsn_request, cdb_lsn_id,
      output cdb_isr_grant, rob_write, rob_id, rob_data,
      output arch_reg_write, arch_reg_id, arch_reg_data, cdb_lsn_hit, cdb_lsn_data
   );

endinterface

// File: rtl/cdb_lane_arbiter.sv
// Multi-grant picker: hands up to BUS_LANES requesters to lanes in fixed or round-robin order.
module cdb_lane_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned ISSUER    = 4,
   parameter int unsigned BUS_LANES = 2,
   parameter int unsigned ARB_MODE  = ARB_FIXED,
   localparam int unsigned IdxW     = idx_width(ISSUER)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [ISSUER-1:0]              req_i,
   output logic [ISSUER-1:0]              grant_o,
   output logic [BUS_LANES-1:0]           lane_valid_o,
   output logic [BUS_LANES-1:0][IdxW-1:0] lane_src_o
);

   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   start, idx, last;
   logic [ISSUER-1:0] taken;
   logic              found;

   always_comb begin
      grant_o      = '0;
      lane_valid_o = '0;
      lane_src_o   = '0;
      taken        = '0;
      found        = 1'b0;
      idx          = '0;
      last         = '0;
      start        = (ARB_MODE == ARB_RR) ? ptr_q : '0;
      // Each lane takes the first not-yet-taken requester in scan order.
      for (int unsigned k = 0; k < BUS_LANES; k++) begin
         found = 1'b0;
         for (int unsigned o = 0; o < ISSUER; o++) begin
            idx = IdxW'((32'(start) + o) % ISSUER);
            if (!found && req_i[idx] && !taken[idx]) begin
               found           = 1'b1;
               taken[idx]      = 1'b1;
               lane_valid_o[k] = 1'b1;
               lane_src_o[k]   = idx;
               last            = idx;
            end
         end
      end
      grant_o = taken;
      ptr_d   = ptr_q;
      if (ARB_MODE == ARB_RR && taken != '0) begin
         ptr_d = (last == IdxW'(ISSUER - 1)) ? '0 : last + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/cdb_multilane.sv
// Multi-lane common data bus: arbitrates producers onto registered lanes and snoops listeners.
// Define CDB_BYPASS_EN to also forward current-cycle grants to the listeners.
module cdb_multilane
   import cdb_pkg::*;
#(
   parameter int unsigned ISSUER              = 4,
   parameter int unsigned LISTENER            = 4,
   parameter int unsigned BUS_LANES           = 2,
   parameter int unsigned ROB_ENTRY           = 4,
   parameter int unsigned ARCH_ENTRY          = 32,
   parameter int unsigned DATA_WIDTH          = 32,
   parameter int unsigned ARB_MODE            = ARB_FIXED,
   parameter logic [ISSUER-1:0] ISSUER_ARCH_REG = (ISSUER)'(1) << (ISSUER - 1)
) (
   input logic            CLK,
   input logic            RSTN,
   cdb_multilane_if.slave bus
);

   localparam int unsigned ROB_ENTRY_LOG2  = idx_width(ROB_ENTRY);
   localparam int unsigned ARCH_ENTRY_LOG2 = idx_width(ARCH_ENTRY);
   localparam int unsigned IdxW            = idx_width(ISSUER);

   typedef struct packed {
      logic                       valid;
      logic                       is_arch;
      logic [ROB_ENTRY_LOG2-1:0]  rob_id;
      logic [ARCH_ENTRY_LOG2-1:0] arch_id;
      logic [DATA_WIDTH-1:0]      data;
   } lane_t;

   lane_t [BUS_LANES-1:0]           lane_d, lane_q;
   logic [ISSUER-1:0]               arb_req, arb_grant;
   logic [BUS_LANES-1:0]            arb_valid;
   logic [BUS_LANES-1:0][IdxW-1:0]  arb_src;
   logic [LISTENER-1:0]             lsn_hit;
   logic [LISTENER*DATA_WIDTH-1:0]  lsn_data;

   // No grants while reset is held, so nothing pending survives the release.
   assign arb_req = bus.cdb_isr_request & {ISSUER{RSTN}};

   cdb_lane_arbiter #(
      .ISSUER   (ISSUER),
      .BUS_LANES(BUS_LANES),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk_i       (CLK),
      .rst_ni      (RSTN),
      .req_i       (arb_req),
      .grant_o     (arb_grant),
      .lane_valid_o(arb_valid),
      .lane_src_o  (arb_src)
   );

   assign bus.cdb_isr_grant = arb_grant;

   always_comb begin
      lane_d = '0;
      for (int unsigned k = 0; k < BUS_LANES; k++) begin
         if (arb_valid[k]) begin
            lane_d[k].valid   = 1'b1;
            lane_d[k].is_arch = ISSUER_ARCH_REG[arb_src[k]];
            lane_d[k].rob_id  = bus.cdb_isr_id[arb_src[k]*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
            lane_d[k].arch_id = bus.cdb_isr_arch_id[arb_src[k]*ARCH_ENTRY_LOG2 +: ARCH_ENTRY_LOG2];
            lane_d[k].data    = bus.cdb_isr_data[arb_src[k]*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   always_comb begin
      bus.rob_write      = '0;
      bus.rob_id         = '0;
      bus.rob_data       = '0;
      bus.arch_reg_write = '0;
      bus.arch_reg_id    = '0;
      bus.arch_reg_data  = '0;
      for (int unsigned k = 0; k < BUS_LANES; k++) begin
         if (lane_q[k].valid && lane_q[k].is_arch) begin
            bus.arch_reg_write[k] = 1'b1;
            bus.arch_reg_id[k*ARCH_ENTRY_LOG2 +: ARCH_ENTRY_LOG2] = lane_q[k].arch_id;
            bus.arch_reg_data[k*DATA_WIDTH +: DATA_WIDTH]         = lane_q[k].data;
         end else if (lane_q[k].valid) begin
            bus.rob_write[k] = 1'b1;
            bus.rob_id[k*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2] = lane_q[k].rob_id;
            bus.rob_data[k*DATA_WIDTH +: DATA_WIDTH]       = lane_q[k].data;
         end
      end
   end

   // First match wins: registered lanes in lane order, then (bypass) current grants.
   always_comb begin
      lsn_hit  = '0;
      lsn_data = '0;
      for (int unsigned j = 0; j < LISTENER; j++) begin
         for (int unsigned k = 0; k < BUS_LANES; k++) begin
            if (bus.cdb_lsn_request[j] && !lsn_hit[j] && lane_q[k].valid &&
                lane_q[k].rob_id == bus.cdb_lsn_id[j*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]) begin
               lsn_hit[j]                            = 1'b1;
               lsn_data[j*DATA_WIDTH +: DATA_WIDTH]  = lane_q[k].data;
            end
         end
`ifdef CDB_BYPASS_EN
         for (int unsigned k = 0; k < BUS_LANES; k++) begin
            if (bus.cdb_lsn_request[j] && !lsn_hit[j] && lane_d[k].valid &&
                lane_d[k].rob_id == bus.cdb_lsn_id[j*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]) begin
               lsn_hit[j]                            = 1'b1;
               lsn_data[j*DATA_WIDTH +: DATA_WIDTH]  = lane_d[k].data;
            end
         end
`endif
      end
   end

   assign bus.cdb_lsn_hit  = lsn_hit;
   assign bus.cdb_lsn_data = lsn_data;

endmodule

// File: tb/tb_cdb_multilane.sv
// Directed bench for cdb_multilane: one fixed-priority and one round-robin instance.
module tb_cdb_multilane;

   logic clk;
   logic rstn;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_multilane_if if0 ();
   cdb_multilane_if if1 ();

   cdb_multilane #(.ARB_MODE(0)) u_dut0 (.CLK(clk), .RSTN(rstn), .bus(if0));
   cdb_multilane #(.ARB_MODE(1)) u_dut1 (.CLK(clk), .RSTN(rstn), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set0(input int i, input logic [1:0] id, input logic [4:0] aid,
                       input logic [31:0] d);
      if0.cdb_isr_id[i*2 +: 2]       = id;
      if0.cdb_isr_arch_id[i*5 +: 5]  = aid;
      if0.cdb_isr_data[i*32 +: 32]   = d;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      if0.cdb_isr_request = 4'hF;
      if1.cdb_isr_request = 4'hF;
      if0.cdb_lsn_request = '0;
      if0.cdb_lsn_id      = '0;
      if1.cdb_lsn_request = '0;
      if1.cdb_lsn_id      = '0;
      for (int i = 0; i < 4; i++) begin
         set0(i, 2'(i), 5'(i + 8), 32'h100 + 32'(i));
         if1.cdb_isr_id[i*2 +: 2]      = 2'(i);
         if1.cdb_isr_arch_id[i*5 +: 5] = 5'(i + 8);
         if1.cdb_isr_data[i*32 +: 32]  = 32'h100 + 32'(i);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++; if (if0.cdb_isr_grant !== 4'b0000) begin n_fail++;
         $display("FAIL rst_grant0: got %b want 0000", if0.cdb_isr_grant); end
      n_tests++; if (if1.cdb_isr_grant !== 4'b0000) begin n_fail++;
         $display("FAIL rst_grant1: got %b want 0000", if1.cdb_isr_grant); end
      n_tests++; if (if0.rob_write !== 2'b00 || if0.arch_reg_write !== 2'b00) begin n_fail++;
         $display("FAIL rst_strobes: got %b/%b want 00/00", if0.rob_write, if0.arch_reg_write); end
      n_tests++; if (if0.rob_data !== 64'h0 || if0.cdb_lsn_hit !== 4'b0) begin n_fail++;
         $display("FAIL rst_data: got %h/%b want 0/0", if0.rob_data, if0.cdb_lsn_hit); end
      @(negedge clk);
      if1.cdb_isr_request = 4'h0;
      rstn = 1'b1;
      #1;
      n_tests++; if (if0.cdb_isr_grant !== 4'b0011) begin n_fail++;
         $display("FAIL rel_grant0: got %b want 0011", if0.cdb_isr_grant); end
      n_tests++; if (if1.cdb_isr_grant !== 4'b0000) begin n_fail++;
         $display("FAIL rel_grant1: got %b want 0000", if1.cdb_isr_grant); end
      edge_sample();
      n_tests++; if (if0.rob_write !== 2'b11 || if0.rob_id !== 4'b0100) begin n_fail++;
         $display("FAIL rel_rob: got %b/%b want 11/0100", if0.rob_write, if0.rob_id); end
      n_tests++; if (if0.rob_data !== {32'h101, 32'h100}) begin n_fail++;
         $display("FAIL rel_rob_data: got %h want 0000010100000100", if0.rob_data); end
      @(negedge clk);
      if0.cdb_isr_request = 4'h0;
      edge_sample();
      n_tests++; if (if0.rob_write !== 2'b00) begin n_fail++;
         $display("FAIL idle_clear: got %b want 00", if0.rob_write); end
   endtask

   task automatic test_fixed_single();
      @(negedge clk);
      set0(1, 2'd2, 5'd0, 32'hA5);
      if0.cdb_isr_request = 4'b0010;
      #1;
      n_tests++; if (if0.cdb_isr_grant !== 4'b0010) begin n_fail++;
         $display("FAIL single_grant: got %b want 0010", if0.cdb_isr_grant); end
      edge_sample();
      n_tests++; if (if0.rob_write !== 2'b01 || if0.rob_id !== 4'h2) begin n_fail++;
         $display("FAIL single_rob: got %b/%h want 01/2", if0.rob_write, if0.rob_id); end
      n_tests++; if (if0.rob_data[31:0] !== 32'hA5 || if0.arch_reg_write !== 2'b00) begin
         n_fail++;
         $display("FAIL single_data: got %h/%b want a5/00", if0.rob_data[31:0], if0.arch_reg_write);
      end
      @(negedge clk);
      if0.cdb_isr_request = 4'b1110;
      #1;
      n_tests++; if (if0.cdb_isr_grant !== 4'b0110) begin n_fail++;
         $display("FAIL overflow_grant: got %b want 0110", if0.cdb_isr_grant); end
      edge_sample();
      n_tests++; if (if0.rob_write !== 2'b11 || if0.arch_reg_write !== 2'b00) begin n_fail++;
         $display("FAIL overflow_lanes: got %b/%b want 11/00", if0.rob_write, if0.arch_reg_write);
      end
      @(negedge clk);
      if0.cdb_isr_request = 4'b0000;
   endtask

   task automatic test_arch_mix();
      @(negedge clk);
      set0(3, 2'd0, 5'd5, 32'h1234);
      set0(0, 2'd1, 5'd0, 32'h7);
      if0.cdb_isr_request = 4'b1001;
      #1;
      n_tests++; if (if0.cdb_isr_grant !== 4'b1001) begin n_fail++;
         $display("FAIL mix_grant: got %b want 1001", if0.cdb_isr_grant); end
      edge_sample();
      n_tests++; if (if0.rob_write !== 2'b01 || if0.rob_id !== 4'h1) begin n_fail++;
         $display("FAIL mix_rob: got %b/%h want 01/1", if0.rob_write, if0.rob_id); end
      n_tests++; if (if0.rob_data !== {32'h0, 32'h7}) begin n_fail++;
         $display("FAIL mix_rob_data: got %h want 0000000000000007", if0.rob_data); end
      n_tests++; if (if0.arch_reg_write !== 2'b10 || if0.arch_reg_id !== {5'd5, 5'd0}) begin
         n_fail++;
         $display("FAIL mix_arch: got %b/%b want 10/0010100000", if0.arch_reg_write,
                  if0.arch_reg_id);
      end
      n_tests++; if (if0.arch_reg_data !== {32'h1234, 32'h0}) begin n_fail++;
         $display("FAIL mix_arch_data: got %h want 0000123400000000", if0.arch_reg_data); end
      @(negedge clk);
      if0.cdb_isr_request = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [3:0] reqs  [6] = '{4'hF, 4'hF, 4'hF, 4'b1001, 4'b0001, 4'b0011};
      logic [3:0] grant [6] = '{4'b0011, 4'b1100, 4'b0011, 4'b1001, 4'b0001, 4'b0011};
      logic [1:0] rw    [6] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
      logic [1:0] aw    [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      logic [63:0] rd   [6] = '{{32'h101, 32'h100}, {32'h0, 32'h102}, {32'h101, 32'h100},
                               {32'h100, 32'h0}, {32'h0, 32'h100}, {32'h100, 32'h101}};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if1.cdb_isr_request = reqs[c];
         #1;
         n_tests++; if (if1.cdb_isr_grant !== grant[c]) begin n_fail++;
            $display("FAIL rr_grant[%0d]: got %b want %b", c, if1.cdb_isr_grant, grant[c]); end
         edge_sample();
         n_tests++; if (if1.rob_write !== rw[c] || if1.arch_reg_write !== aw[c]) begin n_fail++;
            $display("FAIL rr_strobe[%0d]: got %b/%b want %b/%b", c, if1.rob_write,
                     if1.arch_reg_write, rw[c], aw[c]);
         end
         n_tests++; if (if1.rob_data !== rd[c]) begin n_fail++;
            $display("FAIL rr_data[%0d]: got %h want %h", c, if1.rob_data, rd[c]); end
         if (c == 1) begin
            n_tests++; if (if1.arch_reg_id !== {5'd11, 5'd0} ||
                           if1.arch_reg_data !== {32'h103, 32'h0}) begin n_fail++;
               $display("FAIL rr_arch: got %b/%h want 0101100000/0000010300000000",
                        if1.arch_reg_id, if1.arch_reg_data);
            end
         end
      end
      @(negedge clk);
      if1.cdb_isr_request = 4'b0000;
   endtask

   task automatic test_listener();
      @(negedge clk);
      if0.cdb_isr_request = 4'b0000;
      edge_sample();
      @(negedge clk);
      if0.cdb_lsn_request = 4'b0101;
      if0.cdb_lsn_id      = {2'd0, 2'd1, 2'd3, 2'd3};
      set0(2, 2'd3, 5'd0, 32'hDEAD);
      if0.cdb_isr_request = 4'b0100;
      edge_sample();
      n_tests++; if (if0.cdb_lsn_hit !== 4'b0001 || if0.cdb_lsn_data[31:0] !== 32'hDEAD) begin
         n_fail++;
         $display("FAIL lsn_hit: got %b/%h want 0001/dead", if0.cdb_lsn_hit,
                  if0.cdb_lsn_data[31:0]);
      end
      n_tests++; if (if0.cdb_lsn_data[127:32] !== 96'h0) begin n_fail++;
         $display("FAIL lsn_nohit_data: got %h want 0", if0.cdb_lsn_data[127:32]); end
      @(negedge clk);
      set0(0, 2'd3, 5'd0, 32'h1111);
      set0(1, 2'd3, 5'd0, 32'h2222);
      if0.cdb_isr_request = 4'b0011;
      edge_sample();
      n_tests++; if (if0.cdb_lsn_hit !== 4'b0001 || if0.cdb_lsn_data[31:0] !== 32'h1111) begin
         n_fail++;
         $display("FAIL lsn_lane0_prio: got %b/%h want 0001/1111", if0.cdb_lsn_hit,
                  if0.cdb_lsn_data[31:0]);
      end
      @(negedge clk);
      if0.cdb_isr_request = 4'b0000;
      edge_sample();
      n_tests++; if (if0.cdb_lsn_hit !== 4'b0000 || if0.cdb_lsn_data !== 128'h0) begin n_fail++;
         $display("FAIL lsn_idle: got %b/%h want 0/0", if0.cdb_lsn_hit, if0.cdb_lsn_data); end
   endtask

   task automatic test_bypass();
      logic        exp_hit;
      logic [31:0] exp_data;
`ifdef CDB_BYPASS_EN
      exp_hit  = 1'b1;
      exp_data = 32'h55;
`else
      exp_hit  = 1'b0;
      exp_data = 32'h0;
`endif
      @(negedge clk);
      if0.cdb_lsn_request = 4'b0001;
      if0.cdb_lsn_id      = {2'd0, 2'd0, 2'd0, 2'd3};
      set0(0, 2'd3, 5'd0, 32'h55);
      if0.cdb_isr_request = 4'b0001;
      #1;
      n_tests++; if (if0.cdb_lsn_hit[0] !== exp_hit || if0.cdb_lsn_data[31:0] !== exp_data)
      begin
         n_fail++;
         $display("FAIL bypass_same_cycle: got %b/%h want %b/%h", if0.cdb_lsn_hit[0],
                  if0.cdb_lsn_data[31:0], exp_hit, exp_data);
      end
      edge_sample();
      n_tests++; if (if0.cdb_lsn_hit[0] !== 1'b1 || if0.cdb_lsn_data[31:0] !== 32'h55) begin
         n_fail++;
         $display("FAIL bypass_next_cycle: got %b/%h want 1/55", if0.cdb_lsn_hit[0],
                  if0.cdb_lsn_data[31:0]);
      end
      @(negedge clk);
      if0.cdb_isr_request = 4'b0000;
      if0.cdb_lsn_request = 4'b0000;
   endtask

   initial begin
      if0.cdb_isr_request = '0;
      if0.cdb_isr_id      = '0;
      if0.cdb_isr_data    = '0;
      if0.cdb_isr_arch_id = '0;
      if1.cdb_isr_request = '0;
      if1.cdb_isr_id      = '0;
      if1.cdb_isr_data    = '0;
      if1.cdb_isr_arch_id = '0;
      test_reset();
      test_fixed_single();
      test_arch_mix();
      test_round_robin();
      test_listener();
      test_bypass();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
